aes_core_sched: RTL and testbench

- Round sequencer and round-robin arbiter that shares one single-round AES-128 datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey) among N_REQ requesters.
- Accepts one plaintext block at a time and performs the initial AddRoundKey itself.
- Drives the datapath through rounds 1..ROUNDS with the correct round-key index and last-round flag, then returns the ciphertext to the winning requester.
- Sits between the requester ports and the shared round datapath and round-key store.

---
 rtl/aes_core_sched.sv | 150 +++++++++++++++
 tb/tb_aes_core_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_sched.sv
// aes_core_sched: round sequencer and round-robin arbiter sharing one
// single-round AES-128 datapath among N_REQ requesters. Performs the initial
// AddRoundKey, issues rounds 1..ROUNDS with key index and last-round flag,
// and returns the ciphertext (or a timeout error) to the granted requester.
module aes_core_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ROUNDS  = 10,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst1_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*128-1:0]   req_data,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [127:0]           rsp_data,
    output logic                   rsp_err,
    output logic [3:0]             key_idx,
    input  logic [127:0]           key_in,
    output logic                   rnd_start,
    output logic [127:0]           rnd_state,
    output logic                   rnd_last,
    input  logic                   rnd_done,
    input  logic [127:0]           rnd_result,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int unsigned   TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LAST_RND = 4'(ROUNDS);
    localparam logic [2:0]    LAST_REQ = 3'(N_REQ - 1);

    logic [1:0]    fsm_q;
    logic [127:0]  state_q;
    logic [3:0]    round_q;
    logic [TW-1:0] tmo_q;
    logic [2:0]    grant_q;
    logic [2:0]    last_grant_q;
    logic          err_q;

    logic          arb_found;
    logic [2:0]    arb_winner;
    logic [127:0]  arb_data;
    logic          grant_rsp_ready;

    // Round-robin search: first valid requester starting after last_grant, with wrap
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            for (int unsigned r = 0; r < N_REQ; r++) begin
                if (!arb_found && req_valid[r] &&
                    (((32'(last_grant_q) + k) % N_REQ) == r)) begin
                    arb_found  = 1'b1;
                    arb_winner = 3'(r);
                end
            end
        end
    end

    // Per-requester steering: plaintext mux, one-hot accept/response, granted rsp_ready
    always_comb begin
        arb_data        = '0;
        req_ready       = '0;
        rsp_valid       = '0;
        grant_rsp_ready = 1'b0;
        for (int unsigned r = 0; r < N_REQ; r++) begin
            if (3'(r) == arb_winner) begin
                arb_data = req_data[r*128 +: 128];
            end
            if (3'(r) == grant_q) begin
                grant_rsp_ready = rsp_ready[r];
            end
            // gated by reset so no accept is ever signalled while reset is held
            req_ready[r] = rst1_n && (fsm_q == S_IDLE) && arb_found && (3'(r) == arb_winner);
            rsp_valid[r] = (fsm_q == S_RESP) && (3'(r) == grant_q);
        end
    end

    // Sequencer FSM: accept + initial AddRoundKey, issue/wait per round, respond
    always_ff @(posedge clk or negedge rst1_n) begin
        if (!rst1_n) begin
            fsm_q        <= S_IDLE;
            state_q      <= '0;
            round_q      <= '0;
            tmo_q        <= '0;
            grant_q      <= LAST_REQ;
            last_grant_q <= LAST_REQ;
            err_q        <= 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (arb_found) begin
                        state_q <= arb_data ^ key_in;
                        round_q <= 4'd1;
                        grant_q <= arb_winner;
                        fsm_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_q <= '0;
                    fsm_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (rnd_done) begin
                        state_q <= rnd_result;
                        if (round_q == LAST_RND) begin
                            fsm_q <= S_RESP;
                        end else begin
                            round_q <= round_q + 4'd1;
                            fsm_q   <= S_ISSUE;
                        end
                    end else if (tmo_q == TMO_MAX) begin
                        err_q <= 1'b1;
                        fsm_q <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: begin
                    if (grant_rsp_ready) begin
                        last_grant_q <= grant_q;
                        err_q        <= 1'b0;
                        fsm_q        <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Output decode from FSM state and registers
    always_comb begin
        key_idx   = (fsm_q == S_IDLE) ? 4'd0 : round_q;
        rnd_start = (fsm_q == S_ISSUE);
        rnd_last  = ((fsm_q == S_ISSUE) || (fsm_q == S_WAIT)) && (round_q == LAST_RND);
        rnd_state = state_q;
        rsp_data  = ((fsm_q == S_RESP) && !err_q) ? state_q : '0;
        rsp_err   = err_q;
        busy      = (fsm_q != S_IDLE);
        grant_id  = grant_q;
    end

endmodule

// File: tb/tb_aes_core_sched.sv
// tb_aes_core_sched: table-driven bench for aes_core_sched with an AES-128
// round datapath model, key store and reference encryption built in.
module tb_aes_core_sched;

    localparam int N_REQ   = 4;
    localparam int ROUNDS  = 10;
    localparam int TIMEOUT = 64;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                 clk;
    logic                 rst1_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*128-1:0] req_data;
    logic [N_REQ-1:0]     rsp_valid;
    logic [N_REQ-1:0]     rsp_ready;
    logic [127:0]         rsp_data;
    logic                 rsp_err;
    logic [3:0]           key_idx;
    logic [127:0]         key_in;
    logic                 rnd_start;
    logic [127:0]         rnd_state;
    logic                 rnd_last;
    logic                 rnd_done;
    logic [127:0]         rnd_result;
    logic                 busy;
    logic [2:0]           grant_id;

    logic [127:0] pt   [N_REQ];
    logic [127:0] rk   [16];
    logic [7:0]   sbox [256];

    int n_checks = 0;
    int n_fail   = 0;
    int dp_lat    = 1;
    int stall_rnd = 0;
    bit spur      = 1'b0;
    int exp_rnd   = 1;

    typedef struct {
        logic [3:0] mask;
        int         lat;
        int         hold;
        int         stall;
        bit         spur;
        logic [2:0] grant;
        int         exp_lat;
        bit         err;
        bit         fips;
    } txn_t;

    txn_t tbl [10];

    assign key_in   = rk[key_idx];
    assign req_data = {pt[3], pt[2], pt[1], pt[0]};

    aes_core_sched #(.N_REQ(N_REQ), .ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst1_n     (rst1_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .key_idx    (key_idx),
        .key_in     (key_in),
        .rnd_start  (rnd_start),
        .rnd_state  (rnd_state),
        .rnd_last   (rnd_last),
        .rnd_done   (rnd_done),
        .rnd_result (rnd_result),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= ROUNDS) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else             rk[r] = '0;
        end
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   m0, m1, m2, m3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[c*4+r] = a[((c+r)%4)*4 + r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                m0 = b[4*c]; m1 = b[4*c+1]; m2 = b[4*c+2]; m3 = b[4*c+3];
                b[4*c]   = gmul(8'h02, m0) ^ gmul(8'h03, m1) ^ m2 ^ m3;
                b[4*c+1] = m0 ^ gmul(8'h02, m1) ^ gmul(8'h03, m2) ^ m3;
                b[4*c+2] = m0 ^ m1 ^ gmul(8'h02, m2) ^ gmul(8'h03, m3);
                b[4*c+3] = gmul(8'h03, m0) ^ m1 ^ m2 ^ gmul(8'h02, m3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] p);
        logic [127:0] s;
        s = p ^ rk[0];
        for (int r = 1; r <= ROUNDS; r++) s = aes_round(s, rk[r], r == ROUNDS);
        return s;
    endfunction

    // Datapath model: latency dp_lat from rnd_start to rnd_done, optional stall/spurious pulse
    initial begin : dp_model
        int pend;
        logic [127:0] res;
        pend       = 0;
        res        = '0;
        rnd_done   = 1'b0;
        rnd_result = '0;
        forever begin
            @(negedge clk);
            rnd_done = 1'b0;
            if (!rst1_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        rnd_done   = 1'b1;
                        rnd_result = res;
                    end
                end
                if (rnd_start) begin
                    check($sformatf("key_idx_r%0d", exp_rnd), key_idx, exp_rnd);
                    check($sformatf("rnd_last_r%0d", exp_rnd), rnd_last, exp_rnd == ROUNDS);
                    if (exp_rnd != stall_rnd) begin
                        res  = aes_round(rnd_state, key_in, rnd_last);
                        pend = dp_lat;
                    end
                    if (spur) begin
                        rnd_done   = 1'b1;
                        rnd_result = '1;
                    end
                    exp_rnd++;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"},  rsp_data, 0);
        check({tag, "_rsp_err"},   rsp_err, 0);
        check({tag, "_rnd_start"}, rnd_start, 0);
        check({tag, "_rnd_last"},  rnd_last, 0);
        check({tag, "_key_idx"},   key_idx, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_grant_id"},  grant_id, N_REQ - 1);
    endtask

    // Entered and left at negedge+1 of a cycle; requester mask is applied immediately
    task automatic run_txn(input txn_t t, input int idx);
        int n;
        int lat;
        logic [3:0]   oh;
        logic [127:0] exp_data;
        oh        = 4'b0001 << t.grant;
        exp_data  = t.err ? 128'h0 : ref_enc(pt[t.grant]);
        dp_lat    = t.lat;
        stall_rnd = t.stall;
        spur      = t.spur;
        req_valid = t.mask;
        rsp_ready = '0;
        #1;
        n = 0;
        while (req_ready == '0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check($sformatf("t%0d_req_ready", idx), req_ready, oh);
        check($sformatf("t%0d_no_rsp_at_accept", idx), rsp_valid, 0);
        if (req_ready == '0) return;
        exp_rnd = 1;
        lat = 0;
        do begin
            @(negedge clk); #1;
            lat++;
        end while (rsp_valid == '0 && lat < 300);
        check($sformatf("t%0d_latency", idx), lat, t.exp_lat);
        if (rsp_valid == '0) return;
        check($sformatf("t%0d_rsp_valid", idx), rsp_valid, oh);
        check($sformatf("t%0d_grant_id", idx), grant_id, t.grant);
        check($sformatf("t%0d_rsp_err", idx), rsp_err, t.err);
        check($sformatf("t%0d_rsp_data", idx), rsp_data, exp_data);
        if (t.fips) check($sformatf("t%0d_fips_ct", idx), rsp_data, FIPS_CT);
        for (int h = 0; h < t.hold; h++) begin
            rsp_ready = ~oh;
            @(negedge clk); #1;
            check($sformatf("t%0d_hold%0d_rsp_valid", idx, h), rsp_valid, oh);
            check($sformatf("t%0d_hold%0d_rsp_data", idx, h), rsp_data, exp_data);
            check($sformatf("t%0d_hold%0d_req_ready", idx, h), req_ready, 0);
        end
        rsp_ready = oh;
        @(negedge clk); #1;
        rsp_ready = '0;
        check($sformatf("t%0d_busy_after", idx), busy, 0);
        check($sformatf("t%0d_rsp_valid_after", idx), rsp_valid, 0);
    endtask

    initial begin : main
        int n;
        build_sbox();
        expand_key(FIPS_KEY);
        pt[0] = FIPS_PT;
        pt[1] = 128'h3243f6a8885a308d313198a2e0370734;
        pt[2] = 128'h0123456789abcdeffedcba9876543210;
        pt[3] = 128'hffffffff00000000a5a5a5a55a5a5a5a;

        //        mask     L  hold stall spur grant  lat  err  fips
        tbl[0] = '{4'b1111, 1, 0,   0,    1'b0, 3'd0,  21, 1'b0, 1'b1};
        tbl[1] = '{4'b1111, 1, 0,   0,    1'b0, 3'd1,  21, 1'b0, 1'b0};
        tbl[2] = '{4'b1111, 1, 5,   0,    1'b0, 3'd2,  21, 1'b0, 1'b0};
        tbl[3] = '{4'b1111, 1, 0,   0,    1'b0, 3'd3,  21, 1'b0, 1'b0};
        tbl[4] = '{4'b1111, 1, 0,   0,    1'b0, 3'd0,  21, 1'b0, 1'b1};
        tbl[5] = '{4'b1111, 1, 0,   3,    1'b0, 3'd1,  70, 1'b1, 1'b0};
        tbl[6] = '{4'b0100, 1, 0,   0,    1'b0, 3'd2,  21, 1'b0, 1'b0};
        tbl[7] = '{4'b0001, 3, 0,   0,    1'b1, 3'd0,  41, 1'b0, 1'b1};
        tbl[8] = '{4'b0010, 1, 0,   0,    1'b0, 3'd1,  21, 1'b0, 1'b0};
        tbl[9] = '{4'b1111, 1, 0,   0,    1'b0, 3'd0,  21, 1'b0, 1'b1};

        rst1_n    = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        req_valid = '1;
        #1;
        check("rst_req_ready_valid_high", req_ready, 0);
        req_valid = '0;
        rst1_n = 1'b1;
        @(negedge clk); #1;
        check("idle_no_req_busy", busy, 0);

        for (int i = 0; i < 9; i++) run_txn(tbl[i], i);

        // Abort: reset asserted while requester 2 is waiting in round 5
        dp_lat    = 1;
        stall_rnd = 0;
        spur      = 1'b0;
        req_valid = 4'b0100;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("abort_accept", req_ready, 4'b0100);
        exp_rnd = 1;
        repeat (10) @(negedge clk);
        #1;
        check("abort_key_idx_r5", key_idx, 5);
        check("abort_busy", busy, 1);
        rst1_n    = 1'b0;
        req_valid = 4'b1111;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        #1;
        check("abort_rsp_valid_held", rsp_valid, 0);
        rst1_n = 1'b1;
        #1;
        run_txn(tbl[9], 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
